piso_shift_register: RTL and testbench

PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_counter.sv | 26 ++
 rtl/piso_shift_register.sv | 114 +++++++++++
 tb/tb_piso_shift_register.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shift register:
// FSM state type and the bit-counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  function automatic int unsigned piso_cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that tracks the bits of the current frame still to transfer.
module piso_bit_counter #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register with valid/ready serial handshake.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_valid,
  input  logic [WIDTH-1:0]                  load_data,
  output logic                              load_ready,
  output logic                              ser_out,
  output logic                              ser_valid,
  input  logic                              ser_ready,
  output logic                              done,
  output logic [piso_cnt_width(WIDTH)-1:0]  bits_left
);

  localparam int unsigned CW = piso_cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic             done_r;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             load_acc;
  logic             xfer;
  logic             last_data;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign load_acc  = (state == IDLE) && load_valid;
  assign xfer      = ser_valid && ser_ready;
  // Last data bit is pending when only it (and the parity bit, if any) remain.
  assign last_data = (cnt == CW'(FRAME - WIDTH + 1));

  piso_bit_counter #(
    .CW (CW)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (load_acc),
    .load_value (CW'(FRAME)),
    .dec        (xfer),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (load_valid) state_nxt = SHIFT;
      SHIFT: if (xfer && last_data) begin
`ifdef PISO_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = IDLE;
`endif
             end
`ifdef PISO_PARITY_EN
      PARITY: if (xfer) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sh     <= '0;
      done_r <= 1'b0;
`ifdef PISO_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      done_r <= (state != IDLE) && (state_nxt == IDLE);
      if (load_acc) begin
        sh  <= load_data;
`ifdef PISO_PARITY_EN
        par <= ^load_data;
`endif
      end else if (state == SHIFT && xfer) begin
        if (MSB_FIRST != 0) sh <= {sh[WIDTH-2:0], 1'b0};
        else                sh <= {1'b0, sh[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    ser_out = 1'b0;
    unique case (state)
      SHIFT:  ser_out = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];
`ifdef PISO_PARITY_EN
      PARITY: ser_out = par;
`endif
      default: ser_out = 1'b0;
    endcase
  end

  assign load_ready = (state == IDLE);
  assign ser_valid  = (state != IDLE) && !cnt_zero;
  assign done       = done_r;
  assign bits_left  = cnt;

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: a 32-bit MSB-first and an 8-bit LSB-first instance
// checked every cycle against a frame-queue model, plus literal frame expectations.
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        rdy = 1'b0;

  logic       lr32, so32, sv32, dn32;
  logic [5:0] bl32;
  logic       lr8, so8, sv8, dn8;
  logic [3:0] bl8;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(32), .MSB_FIRST(1)) dut32 (
    .clk(clk), .reset(reset), .load_valid(ld_valid), .load_data(ld_data),
    .load_ready(lr32), .ser_out(so32), .ser_valid(sv32), .ser_ready(rdy),
    .done(dn32), .bits_left(bl32));

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clk(clk), .reset(reset), .load_valid(ld_valid), .load_data(ld_data[7:0]),
    .load_ready(lr8), .ser_out(so8), .ser_valid(sv8), .ser_ready(rdy),
    .done(dn8), .bits_left(bl8));

  task automatic chk(input string name, input int d, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, d, got, exp, $time);
    end
  endtask

  // Transmission-order bit list for a word: index 0 goes out first.
  function automatic logic [63:0] build(input logic [31:0] data, input int w, input bit msb);
    logic [63:0] r;
    logic        p;
    r = '0;
    p = 1'b0;
    for (int i = 0; i < w; i++) begin
      r[i] = msb ? data[w-1-i] : data[i];
      p    = p ^ data[i];
    end
    if (P == 1) r[w] = p;
    return r;
  endfunction

  logic [63:0] m_rem [2];
  int          m_n   [2];
  bit          m_busy[2];
  bit          m_done[2];
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int w = (d == 0) ? 32 : 8;
      automatic bit dn = 1'b0;
      if (reset) begin
        m_busy[d] = 1'b0;
        m_n[d]    = 0;
        m_rem[d]  = '0;
      end else if (m_busy[d]) begin
        if (rdy) begin
          m_rem[d] = m_rem[d] >> 1;
          m_n[d]--;
          if (m_n[d] == 0) begin
            m_busy[d] = 1'b0;
            dn = 1'b1;
          end
        end
      end else if (ld_valid) begin
        m_rem[d]  = build(ld_data, w, d == 0);
        m_n[d]    = w + P;
        m_busy[d] = 1'b1;
      end
      m_done[d] = dn;
    end
    if (reset) m_on = 1'b1;
    #1;
    if (m_on) begin
      chk("load_ready", 32, 64'(lr32), 64'(!m_busy[0]));
      chk("ser_valid",  32, 64'(sv32), 64'(m_busy[0]));
      chk("ser_out",    32, 64'(so32), 64'(m_busy[0] ? m_rem[0][0] : 1'b0));
      chk("bits_left",  32, 64'(bl32), 64'(m_busy[0] ? m_n[0] : 0));
      chk("done",       32, 64'(dn32), 64'(m_done[0]));
      chk("load_ready", 8,  64'(lr8),  64'(!m_busy[1]));
      chk("ser_valid",  8,  64'(sv8),  64'(m_busy[1]));
      chk("ser_out",    8,  64'(so8),  64'(m_busy[1] ? m_rem[1][0] : 1'b0));
      chk("bits_left",  8,  64'(bl8),  64'(m_busy[1] ? m_n[1] : 0));
      chk("done",       8,  64'(dn8),  64'(m_done[1]));
    end
  end

  task automatic wait_idle();
    int k;
    ld_valid = 1'b0;
    rdy      = 1'b1;
    k = 0;
    while (!(lr32 && lr8) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 0, 64'(k < 100), 64'd1);
    @(negedge clk);
  endtask

  // Load one word with ser_ready held high and collect both serial streams.
  task automatic frame_run(input logic [31:0] data,
                           output logic [63:0] c32, output logic [63:0] c8,
                           output int d32, output int d8,
                           output int b32, output int b8);
    int k32, k8;
    c32 = '0; c8 = '0; d32 = 0; d8 = 0; b32 = -1; b8 = -1; k32 = 0; k8 = 0;
    ld_valid = 1'b1;
    ld_data  = data;
    rdy      = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      if (sv32) begin
        if (k32 == 0) b32 = int'(bl32);
        c32[k32] = so32;
        k32++;
      end
      if (sv8) begin
        if (k8 == 0) b8 = int'(bl8);
        c8[k8] = so8;
        k8++;
      end
      if (dn32 && d32 == 0) d32 = j;
      if (dn8 && d8 == 0) d8 = j;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] c32, c8;
    int          d32, d8, b32, b8;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_load_ready", 32, 64'(lr32), 64'd1);
    chk("rst_ser_valid",  32, 64'(sv32), 64'd0);
    chk("rst_bits_left",  32, 64'(bl32), 64'd0);
    chk("rst_ser_out",    8,  64'(so8),  64'd0);
    chk("rst_done",       8,  64'(dn8),  64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 0x8000_0001: 32-bit stream 1, thirty 0s, 1; 8-bit stream sends 0x01 LSB first.
    frame_run(32'h8000_0001, c32, c8, d32, d8, b32, b8);
    chk("stream_80000001", 32, c32, 64'h8000_0001);
    chk("done_cycle",      32, 64'(d32), 64'(33 + P));
    chk("first_bits_left", 32, 64'(b32), 64'(32 + P));
    chk("stream_01",       8,  c8, 64'h01 | (64'(P) << 8));
    chk("done_cycle",      8,  64'(d8),  64'(9 + P));
    wait_idle();

    // 0x06 LSB first: 0,1,1,0,0,0,0,0; 32-bit MSB-first puts the ones at positions 29,30.
    frame_run(32'h0000_0006, c32, c8, d32, d8, b32, b8);
    chk("stream_06",       8,  c8, 64'h06);
    chk("first_bits_left", 8,  64'(b8), 64'(8 + P));
    chk("stream_00000006", 32, c32, 64'h6000_0000);
    wait_idle();

    frame_run(32'h0000_0007, c32, c8, d32, d8, b32, b8);
    chk("stream_07_parity1", 8, c8, 64'h07 | (64'(P) << 8));
    chk("done_cycle",        8, 64'(d8), 64'(9 + P));
    wait_idle();
    frame_run(32'h0000_0003, c32, c8, d32, d8, b32, b8);
    chk("stream_03_parity0", 8, c8, 64'h03);
    wait_idle();

    // Stall after four transfers: position 4 of 0xA5 (either order) is 0.
    ld_valid = 1'b1;
    ld_data  = 32'hA5A5_A5A5;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j >= 5) begin
        chk("stall_bits_left", 32, 64'(bl32), 64'(28 + P));
        chk("stall_ser_out",   32, 64'(so32), 64'd0);
        chk("stall_bits_left", 8,  64'(bl8),  64'(4 + P));
        chk("stall_ser_out",   8,  64'(so8),  64'd0);
      end
      rdy = !(j >= 5 && j <= 7);
      @(negedge clk);
    end
    wait_idle();

    // Reset while the 32-bit frame presents bit 10: no done pulse afterwards.
    ld_valid = 1'b1;
    ld_data  = 32'hC3C3_5A5A;
    @(negedge clk);
    ld_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_load_ready", 32, 64'(lr32), 64'd1);
    chk("abort_ser_valid",  32, 64'(sv32), 64'd0);
    chk("abort_bits_left",  32, 64'(bl32), 64'd0);
    for (int j = 0; j < 4; j++) begin
      chk("abort_no_done", 32, 64'(dn32), 64'd0);
      @(negedge clk);
    end

    // load_valid held with all-ones data during frames; loads land only in done cycles.
    ld_valid = 1'b1;
    ld_data  = 32'h1234_5678;
    @(negedge clk);
    ld_data  = 32'hFFFF_FFFF;
    for (int j = 0; j < 120; j++) begin
      rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    wait_idle();

    for (int j = 0; j < 3000; j++) begin
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_data  = $urandom;
      rdy      = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
